// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - data RAM with byte-lane stores, range checking and optional zero-fill (DATA_RAM_INIT_EN)
module data_ram_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        stallreq_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              store_we;
    logic              init_we;
    logic [ADDR_W-1:0] init_idx;
    logic              unused_addr_bits;

    // Word index and range decode; byte offset bits are don't-care for word storage
    assign idx              = addr_i[ADDR_W+1:2];
    assign in_range         = (addr_i[31:ADDR_W+2] == '0);
    assign unused_addr_bits = ^addr_i[1:0];

`ifdef DATA_RAM_INIT_EN
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic [ADDR_W-1:0] init_cnt_nxt;

    // State register and zero-fill counter; reset restarts the fill from index 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Walk every index once, leaving INIT on the edge that clears the last word
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        init_we      = 1'b0;
        case (state)
            ST_INIT: begin
                init_we = 1'b1;
                if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = ST_READY;
                end else begin
                    init_cnt_nxt = init_cnt + 1'b1;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign init_idx = init_cnt;
    assign ready_o  = (state == ST_READY);
`else
    // Without zero-fill the RAM is usable whenever reset is released
    assign init_we  = 1'b0;
    assign init_idx = '0;
    assign ready_o  = rst_n;
`endif

    assign stallreq_o = ~ready_o;
    assign store_we   = ce_i & we_i & ready_o & in_range;

    // Combinational read of committed contents; zero whenever the access is not a valid load
    always_comb begin
        data_o = 32'h0;
        if (ce_i && !we_i && ready_o && in_range) begin
            data_o = mem[idx];
        end
    end

    // Storage update: zero-fill during INIT, otherwise per-lane stores (sel_i[k] owns bits 8k+7:8k)
    always_ff @(posedge clk) begin
        if (init_we && rst_n) begin
            mem[init_idx] <= 32'h0;
        end else if (store_we) begin
            for (int k = 0; k < 4; k++) begin
                if (sel_i[k]) begin
                    mem[idx][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    // Sticky flag for any accepted access that falls outside the RAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (ce_i && ready_o && !in_range) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - directed self-checking bench for data_ram_ctrl (ADDR_W=4)
module tb_data_ram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        stallreq_o;
    logic        err_o;

    int checks;
    int failures;

    data_ram_ctrl #(.ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce_i       (ce_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .sel_i      (sel_i),
        .data_o     (data_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ce_i   = 1'b0;
        we_i   = 1'b0;
        addr_i = 32'h0;
        data_i = 32'h0;
        sel_i  = 4'h0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce_i   = 1'b1;
        we_i   = 1'b1;
        addr_i = a;
        data_i = d;
        sel_i  = s;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        ce_i   = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        #2;
        d = data_o;
        idle();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          n;
        checks   = 0;
        failures = 0;
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_stall", 32'(stallreq_o), 32'd1);
        check("rst_err", 32'(err_o), 32'd0);
        load(32'h0, rd);
        check("rst_load_zero", rd, 32'h0);

`ifdef DATA_RAM_INIT_EN
        // First release, then reset again partway through the zero-fill
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        check("init_ready_low", 32'(ready_o), 32'd0);
        check("init_stall_high", 32'(stallreq_o), 32'd1);
        load(32'h4, rd);
        check("init_load_zero", rd, 32'h0);
        ce_i   = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h80;
        @(posedge clk);
        #1;
        idle();
        check("init_oor_no_err", 32'(err_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midinit_rst_ready", 32'(ready_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(n);
        check("init_cycles", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++) begin
            load(32'(a * 4), rd);
            check($sformatf("zero_fill_%0d", a), rd, 32'h0);
        end
`else
        rst_n = 1'b1;
        #1;
        check("noinit_ready", 32'(ready_o), 32'd1);
        check("noinit_stall", 32'(stallreq_o), 32'd0);
`endif

        store(32'h0, 32'h01020304, 4'hF);
        load(32'h0, rd);
        check("sw_lw_0", rd, 32'h01020304);

        store(32'h8, 32'h11223344, 4'hF);
        store(32'h9, 32'hAAAAAAAA, 4'b0100);
        load(32'h8, rd);
        check("sb_lane", rd, 32'h11AA3344);

        store(32'hC, 32'h55667788, 4'hF);
        store(32'hE, 32'hBEEFBEEF, 4'b0011);
        load(32'hC, rd);
        check("sh_lower", rd, 32'h5566BEEF);

        store(32'hC, 32'hFFFFFFFF, 4'b0000);
        load(32'hC, rd);
        check("sel_zero_nochange", rd, 32'h5566BEEF);
        check("sel_zero_no_err", 32'(err_o), 32'd0);

        ce_i   = 1'b1;
        we_i   = 1'b1;
        addr_i = 32'h8;
        sel_i  = 4'h0;
        #2;
        check("store_data_o_zero", data_o, 32'h0);
        idle();

        store(32'h40, 32'hDEADBEEF, 4'hF);
        check("oor_err_set", 32'(err_o), 32'd1);
        load(32'h0, rd);
        check("oor_no_write", rd, 32'h01020304);
        load(32'h48, rd);
        check("oor_load_zero", rd, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("err_sticky", 32'(err_o), 32'd1);

        rst_n = 1'b0;
        #1;
        check("err_cleared", 32'(err_o), 32'd0);
        check("rst2_ready", 32'(ready_o), 32'd0);
        ce_i   = 1'b1;
        we_i   = 1'b1;
        addr_i = 32'h0;
        data_i = 32'hCAFEF00D;
        sel_i  = 4'hF;
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
`ifdef DATA_RAM_INIT_EN
        wait_ready(n);
        check("reinit_cycles", 32'(n), 32'd16);
        load(32'h0, rd);
        check("reinit_zero", rd, 32'h0);
`else
        #1;
        load(32'h0, rd);
        check("rst_no_write", rd, 32'h01020304);
`endif
        check("err_after_rst", 32'(err_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
